riscv_mem_ctrl: RTL and testbench
=================================

Name: riscv_mem_ctrl

Overview:
- Sequencer and arbiter that shares the CPU's single-port synchronous RAM (ramm) between instruction fetch and load/store.
- Handles byte and half-word lane extraction with sign or zero extension.
- Implements SB/SH as read-modify-write, because the RAM has no byte enables.
- Sits between riscv_cpu and ramm; the CPU stalls on its port until that port's done pulse.

Parameters:
ADDR_W, 8, RAM word-address width (ramm depth = 2^ADDR_W words of 32 bits)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch word address (pc units, one word per pc step)
if_done  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  32  fetched instruction word
ls_req  in  1  load/store request; held with ls_* stable until ls_done
ls_we  in  1  1=store, 0=load
ls_func3  in  3  RV32I func3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
ls_addr  in  32  byte address
ls_wdata  in  32  store data (low byte/half used for SB/SH)
ls_done  out  1  one-cycle pulse; ls_rdata/ls_err valid
ls_rdata  out  32  extended load result; 0 for stores and errors
ls_err  out  1  misaligned access or illegal func3; no RAM access made
ram_address  out  ADDR_W  to ramm.address
ram_data  out  32  to ramm.data
ram_wren  out  1  to ramm.wren
ram_q  in  32  from ramm.q; valid the cycle after the address edge

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE. All registered outputs go to 0. ram_wren drops to 0 immediately. Asserting reset in any state aborts the operation: no done pulse, and no write if the write edge has not yet occurred.
- The ram_* outputs are combinational from state and latched request registers. All other outputs are registered.
- States: IDLE, ISSUE, CAPTURE, MERGE.
- IDLE arbitration:
  - ls_req has priority over if_req.
  - A port whose done output is high this cycle is ignored, so the requester can drop req in its done cycle.
  - The winner's address, func3, we and wdata are latched.
  - Data word address = ls_addr[ADDR_W+1:2]. Higher bits are ignored, so addresses wrap.
- Error check, made in IDLE:
  - Error conditions: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load func3 in {011,110,111}; store func3 >= 011.
  - Response: next edge sets ls_done=1 and ls_err=1, rdata=0, state stays IDLE.
- ISSUE: ram_address = latched word address, ram_data = ls_wdata.
  - SW: ram_wren=1. Next: IDLE with ls_done=1.
  - Fetch, load, SB, SH: ram_wren=0. Next: CAPTURE (fetch/load) or MERGE (SB/SH).
- CAPTURE: ram_q is valid.
  - Fetch: if_rdata <= ram_q, if_done <= 1.
  - Load, with lane chosen by addr[1:0]:
    - LB: sign-extended byte.
    - LBU: zero-extended byte.
    - LH: sign-extended half; addr[1] selects the upper half.
    - LHU: zero-extended half.
    - LW: full word.
    - Then ls_rdata <= result, ls_done <= 1.
  - Next: IDLE.
- MERGE: ram_q is valid.
  - ram_data = ram_q with the addressed byte or half replaced by wdata[7:0] / wdata[15:0]. ram_wren=1, same address.
  - Next: IDLE with ls_done=1.
- Latency, counted as edges from the first edge sampling req in IDLE to the done-high cycle:
  - error 1; SW 2; fetch, load, LW 3; SB/SH 3.
  - Add 1 for each cycle lost to arbitration.
- Done pulses last exactly one cycle. if_done and ls_done are never high together.
- The block has one access in flight and no queuing.

Optional Feature:
- Macro: RISCV_MEM_CTRL_RR_ARB_EN.
- Defined: round-robin arbitration. A last_grant flag, reset to fetch, is updated on every grant. When both ports request in IDLE, the port not granted last wins.
- Undefined: fixed ls-over-if priority. Fetch can starve under back-to-back load/store traffic.

Test Plan:
- RAM[5]=0x80FF7F01. LB at byte addr 0x15 -> ls_rdata=0x0000007F. LB at 0x17 -> 0xFFFFFF80. LBU at 0x17 -> 0x00000080. LHU at 0x16 -> 0x000080FF. Each with ls_done 3 edges after the request.
- RAM[2]=0x11223344. SB addr 0x09, wdata 0xAA -> RAM[2]=0x1122AA44 after 3 edges. Then SH addr 0x0A, wdata 0xBEEF -> RAM[2]=0xBEEFAA44.
- SW addr 0x0C, wdata 0xDEADBEEF -> ls_done at edge 2, RAM[3]=0xDEADBEEF. LW at 0x0C -> ls_rdata=0xDEADBEEF.
- LW at addr 0x06, then SH at addr 0x03 -> each returns ls_done=1, ls_err=1 at edge 1, with ram_wren never asserted.
- if_req and ls_req asserted in the same cycle:
  - without the macro -> ls serviced first, if_done follows 3 cycles later;
  - with the macro and last_grant=ls -> fetch serviced first.
- SB in flight: assert reset in the MERGE cycle before the edge -> RAM word unchanged, no done pulse, state IDLE, all outputs 0.

Source files
------------

// File: rtl/riscv_mem_ctrl_if.sv
// riscv_mem_ctrl_if: CPU-side fetch and load/store handshake bundle for riscv_mem_ctrl.
// The master modport is the CPU side; the slave modport is the memory controller.
interface riscv_mem_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [31:0]       if_rdata;
   logic              ls_req;
   logic              ls_we;
   logic [2:0]        ls_func3;
   logic [31:0]       ls_addr;
   logic [31:0]       ls_wdata;
   logic              ls_done;
   logic [31:0]       ls_rdata;
   logic              ls_err;

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_func3, ls_addr, ls_wdata,
      input  if_done, if_rdata, ls_done, ls_rdata, ls_err
   );

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_func3, ls_addr, ls_wdata,
      output if_done, if_rdata, ls_done, ls_rdata, ls_err
   );
endinterface

// File: rtl/riscv_mem_ctrl.sv
// riscv_mem_ctrl: shares one single-port synchronous RAM between instruction
// fetch and load/store. Sub-word loads are lane-extracted and extended; SB/SH
// become read-modify-write because the RAM has no byte enables.
// Optional build macro RISCV_MEM_CTRL_RR_ARB_EN: round-robin arbitration
// instead of fixed load/store-over-fetch priority.
module riscv_mem_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   riscv_mem_ctrl_if.slave   bus,
   output logic [ADDR_W-1:0] ram_address,
   output logic [31:0]       ram_data,
   output logic              ram_wren,
   input  logic [31:0]       ram_q
);
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, MERGE = 2'd3} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Misaligned or undefined func3; such requests never touch the RAM.
   function automatic logic ls_illegal(logic we, logic [2:0] f3, logic [1:0] off);
      logic bad;
      if (we) begin
         case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

   // Select the addressed byte/half and extend it according to func3.
   function automatic logic [31:0] load_lane(logic [2:0] f3, logic [1:0] off, logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_BU:   r = {24'd0, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_HU:   r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed byte/half of the old word with the store data.
   function automatic logic [31:0] store_merge(logic [2:0] f3, logic [1:0] off, logic [31:0] word, logic [31:0] wd);
      logic [31:0] r;
      r = word;
      if (f3 == F3_B) begin
         case (off)
            2'd0:    r[7:0]   = wd[7:0];
            2'd1:    r[15:8]  = wd[7:0];
            2'd2:    r[23:16] = wd[7:0];
            default: r[31:24] = wd[7:0];
         endcase
      end else if (f3 == F3_H) begin
         if (off[1]) begin
            r[31:16] = wd[15:0];
         end else begin
            r[15:0] = wd[15:0];
         end
      end else begin
         r = wd;
      end
      return r;
   endfunction

   state_t            state_r, state_nxt_s;
   logic              fetch_r, fetch_nxt_s;
   logic              we_r, we_nxt_s;
   logic [2:0]        func3_r, func3_nxt_s;
   logic [1:0]        off_r, off_nxt_s;
   logic [ADDR_W-1:0] waddr_r, waddr_nxt_s;
   logic [31:0]       wdata_r, wdata_nxt_s;
   logic              if_done_r, if_done_nxt_s;
   logic [31:0]       if_rdata_r, if_rdata_nxt_s;
   logic              ls_done_r, ls_done_nxt_s;
   logic [31:0]       ls_rdata_r, ls_rdata_nxt_s;
   logic              ls_err_r, ls_err_nxt_s;
   logic              ls_cand_s, if_cand_s, grant_ls_s, grant_if_s, is_sw_s;
   logic              unused_addr_s;

   // Upper byte-address bits beyond the RAM are ignored so accesses wrap.
   assign unused_addr_s = ^bus.ls_addr[31:ADDR_W+2];

   // A port whose done is high this cycle is not eligible, so it may drop req late.
   assign ls_cand_s = bus.ls_req & ~ls_done_r;
   assign if_cand_s = bus.if_req & ~if_done_r;

`ifdef RISCV_MEM_CTRL_RR_ARB_EN
   logic last_grant_r;  // 1 = load/store was granted last, 0 = fetch

   assign grant_ls_s = ls_cand_s & (~if_cand_s | ~last_grant_r);

   // Remember which port won the most recent grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_r <= 1'b0;
      end else if ((state_r == IDLE) && (grant_ls_s || grant_if_s)) begin
         last_grant_r <= grant_ls_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end
`else
   assign grant_ls_s = ls_cand_s;
`endif

   assign grant_if_s = if_cand_s & ~grant_ls_s;
   assign is_sw_s    = ~fetch_r & we_r & (func3_r == F3_W);

   assign bus.if_done  = if_done_r;
   assign bus.if_rdata = if_rdata_r;
   assign bus.ls_done  = ls_done_r;
   assign bus.ls_rdata = ls_rdata_r;
   assign bus.ls_err   = ls_err_r;

   // Sequencer next state, request latching and next registered outputs.
   always_comb begin
      state_nxt_s    = state_r;
      fetch_nxt_s    = fetch_r;
      we_nxt_s       = we_r;
      func3_nxt_s    = func3_r;
      off_nxt_s      = off_r;
      waddr_nxt_s    = waddr_r;
      wdata_nxt_s    = wdata_r;
      if_done_nxt_s  = 1'b0;
      if_rdata_nxt_s = if_rdata_r;
      ls_done_nxt_s  = 1'b0;
      ls_rdata_nxt_s = ls_rdata_r;
      ls_err_nxt_s   = ls_err_r;
      case (state_r)
         IDLE: begin
            if (grant_ls_s) begin
               if (ls_illegal(bus.ls_we, bus.ls_func3, bus.ls_addr[1:0])) begin
                  ls_done_nxt_s  = 1'b1;
                  ls_err_nxt_s   = 1'b1;
                  ls_rdata_nxt_s = 32'd0;
               end else begin
                  state_nxt_s = ISSUE;
                  fetch_nxt_s = 1'b0;
                  we_nxt_s    = bus.ls_we;
                  func3_nxt_s = bus.ls_func3;
                  off_nxt_s   = bus.ls_addr[1:0];
                  waddr_nxt_s = bus.ls_addr[ADDR_W+1:2];
                  wdata_nxt_s = bus.ls_wdata;
               end
            end else if (grant_if_s) begin
               state_nxt_s = ISSUE;
               fetch_nxt_s = 1'b1;
               we_nxt_s    = 1'b0;
               func3_nxt_s = F3_W;
               off_nxt_s   = 2'd0;
               waddr_nxt_s = bus.if_addr;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (is_sw_s) begin
               state_nxt_s    = IDLE;
               ls_done_nxt_s  = 1'b1;
               ls_err_nxt_s   = 1'b0;
               ls_rdata_nxt_s = 32'd0;
            end else if (we_r) begin
               state_nxt_s = MERGE;
            end else begin
               state_nxt_s = CAPTURE;
            end
         end
         CAPTURE: begin
            state_nxt_s = IDLE;
            if (fetch_r) begin
               if_rdata_nxt_s = ram_q;
               if_done_nxt_s  = 1'b1;
            end else begin
               ls_rdata_nxt_s = load_lane(func3_r, off_r, ram_q);
               ls_err_nxt_s   = 1'b0;
               ls_done_nxt_s  = 1'b1;
            end
         end
         MERGE: begin
            state_nxt_s    = IDLE;
            ls_done_nxt_s  = 1'b1;
            ls_err_nxt_s   = 1'b0;
            ls_rdata_nxt_s = 32'd0;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, latched request and registered outputs; reset aborts any access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         fetch_r    <= 1'b0;
         we_r       <= 1'b0;
         func3_r    <= 3'd0;
         off_r      <= 2'd0;
         waddr_r    <= '0;
         wdata_r    <= 32'd0;
         if_done_r  <= 1'b0;
         if_rdata_r <= 32'd0;
         ls_done_r  <= 1'b0;
         ls_rdata_r <= 32'd0;
         ls_err_r   <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         fetch_r    <= fetch_nxt_s;
         we_r       <= we_nxt_s;
         func3_r    <= func3_nxt_s;
         off_r      <= off_nxt_s;
         waddr_r    <= waddr_nxt_s;
         wdata_r    <= wdata_nxt_s;
         if_done_r  <= if_done_nxt_s;
         if_rdata_r <= if_rdata_nxt_s;
         ls_done_r  <= ls_done_nxt_s;
         ls_rdata_r <= ls_rdata_nxt_s;
         ls_err_r   <= ls_err_nxt_s;
      end
   end

   // RAM port drive; write enable only in the SW issue cycle or the merge cycle.
   always_comb begin
      ram_address = waddr_r;
      ram_data    = wdata_r;
      ram_wren    = 1'b0;
      case (state_r)
         ISSUE: begin
            ram_wren = is_sw_s;
         end
         MERGE: begin
            ram_data = store_merge(func3_r, off_r, ram_q, wdata_r);
            ram_wren = 1'b1;
         end
         default: begin
            ram_wren = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_riscv_mem_ctrl.sv
// tb_riscv_mem_ctrl: randomized and directed bench for riscv_mem_ctrl with a
// behavioural RAM-content and timing model and a per-cycle compare process.
module tb_riscv_mem_ctrl;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;
`ifdef RISCV_MEM_CTRL_RR_ARB_EN
   localparam bit RR_ARB = 1'b1;
`else
   localparam bit RR_ARB = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] ram_address;
   logic [31:0]       ram_data;
   logic              ram_wren;
   logic [31:0]       ram_q;

   riscv_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   riscv_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic        load_ram = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   bit          wren_ok = 1'b0;
   bit          last_ls = 1'b0;

   typedef struct {
      int          cyc;
      bit          is_ls;
      logic [31:0] rdata;
      bit          err;
      bit          mem_chk;
      int          widx;
      logic [31:0] wval;
   } exp_t;
   exp_t expq[$];

   // Stand-in for ramm: synchronous write, registered read, optional bulk preload.
   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
      end else if (ram_wren) begin
         ram[ram_address] <= ram_data;
      end
      ram_q <= ram[ram_address];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
      int size;
      bit legal;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
      size = 1 << f3[1:0];
      return (int'(addr[1:0]) % size) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] v, b, h;
      v = word >> (8 * off);
      b = v & 32'h0000_00FF;
      h = v & 32'h0000_FFFF;
      if (f3 == 3'd0) return (b >= 32'd128) ? b - 32'd256 : b;
      if (f3 == 3'd4) return b;
      if (f3 == 3'd1) return (h >= 32'd32768) ? h - 32'd65536 : h;
      if (f3 == 3'd5) return h;
      return word;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] wd);
      logic [31:0] mask;
      if (f3 == 3'd2) return wd;
      mask = (f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
      return (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
   endfunction

   // Per-cycle compare: done pulses must appear exactly when the model says.
   initial begin : compare
      bit exp_ls, exp_if;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            exp_ls = 1'b0;
            exp_if = 1'b0;
            for (int i = expq.size() - 1; i >= 0; i--) begin
               if (expq[i].cyc == cyc) begin
                  if (expq[i].is_ls) begin
                     exp_ls = 1'b1;
                     check("ls_rdata", bus.ls_rdata, expq[i].rdata);
                     check("ls_err", {31'd0, bus.ls_err}, {31'd0, expq[i].err});
                     if (expq[i].mem_chk) check("ram_word", ram[expq[i].widx], expq[i].wval);
                  end else begin
                     exp_if = 1'b1;
                     check("if_rdata", bus.if_rdata, expq[i].rdata);
                  end
                  expq.delete(i);
               end else if (expq[i].cyc < cyc) begin
                  expq.delete(i);
               end
            end
            check("ls_done", {31'd0, bus.ls_done}, {31'd0, exp_ls});
            check("if_done", {31'd0, bus.if_done}, {31'd0, exp_if});
            if (!wren_ok) check("ram_wren_quiet", {31'd0, ram_wren}, 32'd0);
         end
      end
   end

   task automatic wait_done(input bit is_ls, output logic [31:0] rd, output logic er);
      bit seen;
      seen = 1'b0;
      rd = 32'd0;
      er = 1'b0;
      for (int t = 0; t < 16 && !seen; t++) begin
         @(negedge clk);
         if (is_ls ? bus.ls_done : bus.if_done) begin
            seen = 1'b1;
            rd = is_ls ? bus.ls_rdata : bus.if_rdata;
            er = is_ls ? bus.ls_err : 1'b0;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout port=%s actual=no-done required=done within 16 cycles", is_ls ? "ls" : "if");
      end
   endtask

   task automatic run_ls(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
      exp_t x;
      bit   e;
      int   idx;
      idx = int'(addr[ADDR_W+1:2]);
      e = model_err(we, f3, addr);
      @(negedge clk);
      x.cyc     = cyc + (e ? 1 : ((we && f3 == 3'd2) ? 2 : 3));
      x.is_ls   = 1'b1;
      x.err     = e;
      x.mem_chk = we;
      x.widx    = idx;
      x.rdata   = (e || we) ? 32'd0 : model_load(ref_mem[idx], f3, addr[1:0]);
      if (we && !e) ref_mem[idx] = model_store(ref_mem[idx], f3, addr[1:0], wd);
      x.wval    = ref_mem[idx];
      expq.push_back(x);
      last_ls = 1'b1;
      wren_ok = we && !e;
      bus.ls_we = we; bus.ls_func3 = f3; bus.ls_addr = addr; bus.ls_wdata = wd; bus.ls_req = 1'b1;
      wait_done(1'b1, rd, er);
      bus.ls_req = 1'b0;
      wren_ok = 1'b0;
   endtask

   task automatic run_if(input logic [ADDR_W-1:0] a, output logic [31:0] rd);
      exp_t x;
      logic er;
      @(negedge clk);
      x.cyc = cyc + 3; x.is_ls = 1'b0; x.rdata = ref_mem[a]; x.err = 1'b0;
      x.mem_chk = 1'b0; x.widx = 0; x.wval = 32'd0;
      expq.push_back(x);
      last_ls = 1'b0;
      bus.if_addr = a; bus.if_req = 1'b1;
      wait_done(1'b0, rd, er);
      bus.if_req = 1'b0;
   endtask

   // Fetch and an aligned load raised together; winner done at +3, loser at +6.
   task automatic run_both(input logic [ADDR_W-1:0] fa, input logic [31:0] la, input logic [2:0] f3);
      exp_t xl, xf;
      bit   ls_first, got_l, got_f;
      ls_first = RR_ARB ? !last_ls : 1'b1;
      @(negedge clk);
      xl.cyc = cyc + (ls_first ? 3 : 6); xl.is_ls = 1'b1; xl.err = 1'b0; xl.mem_chk = 1'b0;
      xl.widx = 0; xl.wval = 32'd0;
      xl.rdata = model_load(ref_mem[int'(la[ADDR_W+1:2])], f3, la[1:0]);
      xf.cyc = cyc + (ls_first ? 6 : 3); xf.is_ls = 1'b0; xf.err = 1'b0; xf.mem_chk = 1'b0;
      xf.widx = 0; xf.wval = 32'd0; xf.rdata = ref_mem[fa];
      expq.push_back(xl);
      expq.push_back(xf);
      last_ls = !ls_first;
      bus.ls_we = 1'b0; bus.ls_func3 = f3; bus.ls_addr = la; bus.ls_wdata = $urandom; bus.ls_req = 1'b1;
      bus.if_addr = fa; bus.if_req = 1'b1;
      got_l = 1'b0;
      got_f = 1'b0;
      for (int t = 0; t < 24 && !(got_l && got_f); t++) begin
         @(negedge clk);
         if (bus.ls_done) begin bus.ls_req = 1'b0; got_l = 1'b1; end
         if (bus.if_done) begin bus.if_req = 1'b0; got_f = 1'b1; end
      end
      if (!(got_l && got_f)) begin
         checks++;
         failures++;
         $display("FAIL both_timeout actual=ls:%0d if:%0d required=both done", got_l, got_f);
      end
      bus.ls_req = 1'b0;
      bus.if_req = 1'b0;
   endtask

   initial begin : main
      logic [31:0] rd, addr;
      logic        er;
      logic [2:0]  f3;
      bit          we;
      reset = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0; bus.ls_req = 1'b0; bus.ls_we = 1'b0;
      bus.ls_func3 = 3'd0; bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
      ref_mem[5] = 32'h80FF_7F01;
      ref_mem[2] = 32'h1122_3344;
      load_ram = 1'b1;
      #1;
      check("rst_if_done", {31'd0, bus.if_done}, 32'd0);
      check("rst_if_rdata", bus.if_rdata, 32'd0);
      check("rst_ls_done", {31'd0, bus.ls_done}, 32'd0);
      check("rst_ls_rdata", bus.ls_rdata, 32'd0);
      check("rst_ls_err", {31'd0, bus.ls_err}, 32'd0);
      check("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
      repeat (3) @(negedge clk);
      load_ram = 1'b0;
      reset = 1'b1;

      // Directed lane extraction.
      run_ls(1'b0, 3'd0, 32'h15, 32'd0, rd, er); check("lb_15", rd, 32'h0000_007F);
      run_ls(1'b0, 3'd0, 32'h17, 32'd0, rd, er); check("lb_17", rd, 32'hFFFF_FF80);
      run_ls(1'b0, 3'd4, 32'h17, 32'd0, rd, er); check("lbu_17", rd, 32'h0000_0080);
      run_ls(1'b0, 3'd5, 32'h16, 32'd0, rd, er); check("lhu_16", rd, 32'h0000_80FF);
      run_if(8'd5, rd);                          check("fetch_5", rd, 32'h80FF_7F01);
      // Directed read-modify-write and full-word store.
      run_ls(1'b1, 3'd0, 32'h09, 32'h0000_00AA, rd, er); check("sb_09", ram[2], 32'h1122_AA44);
      run_ls(1'b1, 3'd1, 32'h0A, 32'h0000_BEEF, rd, er); check("sh_0a", ram[2], 32'hBEEF_AA44);
      run_ls(1'b1, 3'd2, 32'h0C, 32'hDEAD_BEEF, rd, er); check("sw_0c", ram[3], 32'hDEAD_BEEF);
      run_ls(1'b0, 3'd2, 32'h0C, 32'd0, rd, er);         check("lw_0c", rd, 32'hDEAD_BEEF);
      // Misaligned accesses.
      run_ls(1'b0, 3'd2, 32'h06, 32'd0, rd, er);         check("lw_06_err", {31'd0, er}, 32'd1);
      run_ls(1'b1, 3'd1, 32'h03, 32'h1234, rd, er);      check("sh_03_err", {31'd0, er}, 32'd1);
      // Simultaneous requests after a load/store grant and after a fetch grant.
      run_both(8'd5, 32'h0C, 3'd2);
      run_if(8'd2, rd);
      run_both(8'd3, 32'h14, 3'd2);

      // Randomized traffic with wrapping addresses.
      for (int n = 0; n < 150; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         case ($urandom_range(0, 5))
            0: run_if(ADDR_W'($urandom_range(0, DEPTH - 1)), rd);
            1: run_both(ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom & 32'hFFFF_FFFC, 3'd2);
            default: begin
               we   = 1'($urandom_range(0, 1));
               f3   = 3'($urandom_range(0, 7));
               addr = $urandom;
               if ($urandom_range(0, 3) != 0) begin
                  if (f3[1:0] == 2'd2) addr[1:0] = 2'd0;
                  else if (f3[1:0] == 2'd1) addr[0] = 1'b0;
               end
               run_ls(we, f3, addr, $urandom, rd, er);
            end
         endcase
      end

      // Reset in the merge cycle of an SB must suppress the write and the done pulse.
      @(negedge clk);
      wren_ok = 1'b1;
      bus.ls_we = 1'b1; bus.ls_func3 = 3'd0; bus.ls_addr = 32'h25; bus.ls_wdata = 32'h0000_0055; bus.ls_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("merge_wren", {31'd0, ram_wren}, 32'd1);
      reset = 1'b0;
      #1;
      check("abort_wren", {31'd0, ram_wren}, 32'd0);
      check("abort_ls_done", {31'd0, bus.ls_done}, 32'd0);
      check("abort_ls_rdata", bus.ls_rdata, 32'd0);
      check("abort_if_rdata", bus.if_rdata, 32'd0);
      check("abort_ls_err", {31'd0, bus.ls_err}, 32'd0);
      bus.ls_req = 1'b0;
      wren_ok = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      last_ls = 1'b0;
      check("abort_ram_kept", ram[9], ref_mem[9]);
      run_ls(1'b0, 3'd2, 32'h24, 32'd0, rd, er);
      run_both(8'd9, 32'h24, 3'd2);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
